uart_tx_controller: RTL and testbench

//  Avalon-MM master that drains 16-bit words from the tri-port instruction memory into the UART data register.
//  It is the transmit counterpart of uart_controller. Each word is split into two bytes, low byte first.

---
 rtl/uart_tx_controller_if.sv | 35 +++
 rtl/uart_tx_controller.sv | 152 +++++++++++++++
 tb/tb_uart_tx_controller.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_controller_if.sv
// Bus bundle for uart_tx_controller: start/status handshake, instruction-memory
// read port and the Avalon-MM master port towards the UART.
// master = controller side, slave = environment (memory, UART, sequencer).
interface uart_tx_controller_if #(
  parameter int ADDRESS_WIDTH = 11
);
  logic                     start_in;
  logic [ADDRESS_WIDTH-1:0] start_address_in;
  logic [ADDRESS_WIDTH-1:0] word_count_in;
  logic [ADDRESS_WIDTH-1:0] memory_address_out;
  logic [15:0]              memory_data_in;
  logic [31:0]              readdata_in;
  logic                     waitrequest_in;
  logic                     chipselect_out;
  logic                     address_out;
  logic                     read_n_out;
  logic                     write_n_out;
  logic [31:0]              writedata_out;
  logic                     busy_out;
  logic                     done_out;

  modport master (
    input  start_in, start_address_in, word_count_in, memory_data_in,
           readdata_in, waitrequest_in,
    output memory_address_out, chipselect_out, address_out, read_n_out,
           write_n_out, writedata_out, busy_out, done_out
  );

  modport slave (
    output start_in, start_address_in, word_count_in, memory_data_in,
           readdata_in, waitrequest_in,
    input  memory_address_out, chipselect_out, address_out, read_n_out,
           write_n_out, writedata_out, busy_out, done_out
  );
endinterface

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: drains 16-bit instruction-memory words into the UART
// data register, low byte first, polling the control register WSPACE field
// before byte writes.
// Optional feature macro: UART_TX_WSPACE_CACHE_EN -- caches the polled WSPACE
// as write credit so consecutive byte writes can skip the poll.
module uart_tx_controller #(
  parameter int ADDRESS_WIDTH = 11
) (
  input logic                 clock_in,
  input logic                 reset_in,
  uart_tx_controller_if.master bus
);

  // POLL_GAP / WR_GAP are the mandatory idle cycles between two bus transactions
  typedef enum logic [3:0] {
    S_IDLE, S_MEM_RD, S_MEM_LATCH, S_POLL, S_POLL_GAP,
    S_WR_GAP, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] ptr;
  logic [ADDRESS_WIDTH-1:0] remaining;
  logic [15:0]              hold;
  logic                     byte_hi;
  logic                     busy_q, done_q;
  logic                     credit_ok;
  logic [15:0]              wspace;
  logic                     cs_c, addr_c, rd_n_c, wr_n_c;
  logic [31:0]              wdata_c;
  logic                     unused_low_bits;

  assign wspace          = bus.readdata_in[31:16];
  assign unused_low_bits = ^bus.readdata_in[15:0];

`ifdef UART_TX_WSPACE_CACHE_EN
  logic [15:0] credit;

  // Credit loads from a successful poll and burns one per completed byte write
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in)
      credit <= 16'd0;
    else if (state == S_IDLE)
      credit <= 16'd0;
    else if (state == S_POLL && !bus.waitrequest_in && wspace != 16'd0)
      credit <= wspace;
    else if (state == S_WRITE && !bus.waitrequest_in && credit != 16'd0)
      credit <= credit - 16'd1;
  end

  assign credit_ok = (credit != 16'd0);
`else
  assign credit_ok = 1'b0;
`endif

  // State register
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and bus strobes; strobes decode straight from state so reset
  // drops them asynchronously
  always_comb begin
    state_nxt = state;
    cs_c      = 1'b0;
    addr_c    = 1'b0;
    rd_n_c    = 1'b1;
    wr_n_c    = 1'b1;
    wdata_c   = 32'h0;
    case (state)
      S_IDLE:      if (bus.start_in)
                     state_nxt = (bus.word_count_in == '0) ? S_DONE : S_MEM_RD;
      S_MEM_RD:    state_nxt = S_MEM_LATCH;
      S_MEM_LATCH: state_nxt = credit_ok ? S_WRITE : S_POLL;
      S_POLL: begin
        cs_c   = 1'b1;
        addr_c = 1'b1;
        rd_n_c = 1'b0;
        if (!bus.waitrequest_in)
          state_nxt = (wspace != 16'd0) ? S_WR_GAP : S_POLL_GAP;
      end
      S_POLL_GAP:  state_nxt = S_POLL;
      S_WR_GAP:    state_nxt = S_WRITE;
      S_WRITE: begin
        cs_c    = 1'b1;
        wr_n_c  = 1'b0;
        wdata_c = {24'h0, byte_hi ? hold[15:8] : hold[7:0]};
        if (!bus.waitrequest_in) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (!byte_hi)
          state_nxt = credit_ok ? S_WRITE : S_POLL;
        else
          state_nxt = (remaining == ADDRESS_WIDTH'(1)) ? S_DONE : S_MEM_RD;
      end
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Pointer, word counter, holding register and byte select
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      ptr       <= '0;
      remaining <= '0;
      hold      <= 16'h0;
      byte_hi   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.start_in) begin
          ptr       <= bus.start_address_in;
          remaining <= bus.word_count_in;
        end
        S_MEM_LATCH: begin
          hold    <= bus.memory_data_in;
          byte_hi <= 1'b0;
        end
        S_NEXT: begin
          if (!byte_hi) begin
            byte_hi <= 1'b1;
          end else begin
            ptr       <= ptr + ADDRESS_WIDTH'(1);
            remaining <= remaining - ADDRESS_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Status: busy from accepted start; done pulses as busy falls
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_DONE);
      if (state == S_IDLE && bus.start_in) busy_q <= 1'b1;
      else if (state == S_DONE)            busy_q <= 1'b0;
    end
  end

  assign bus.memory_address_out = ptr;
  assign bus.chipselect_out     = cs_c;
  assign bus.address_out        = addr_c;
  assign bus.read_n_out         = rd_n_c;
  assign bus.write_n_out        = wr_n_c;
  assign bus.writedata_out      = wdata_c;
  assign bus.busy_out           = busy_q;
  assign bus.done_out           = done_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Bench for uart_tx_controller: memory + UART slave responders, a
// transaction-level reference model and directed/randomized transfers.
module tb_uart_tx_controller;
  localparam int AW = 11;

  logic clock_in = 1'b0;
  logic reset_in;

  uart_tx_controller_if #(.ADDRESS_WIDTH(AW)) bus ();
  uart_tx_controller #(.ADDRESS_WIDTH(AW)) dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clock_in = ~clock_in;

  int          total  = 0;
  int          passes = 0;
  logic [15:0] mem [0:2047];
  int          slave_ws[$];
  int          def_ws;
  int          stall_cfg;
  int          log_q[$];
  int          exp_q[$];
  int          stall_cnt  = 0;
  int          cs_cycles  = 0;
  int          gap_viol   = 0;
  int          unstable   = 0;
  bit          saw_zero   = 0;
  bit          prev_done  = 0;
  bit          cache      = 0;
  logic [35:0] snap;

  // synchronous-read instruction memory
  always @(posedge clock_in) bus.memory_data_in <= mem[bus.memory_address_out];

  // UART slave: stalls stall_cfg cycles, returns WSPACE from slave_ws, logs
  // each completed transaction (-1 = control read, else write data)
  always @(negedge clock_in) begin : uart_slave
    int          r;
    logic [15:0] ws;
    logic [35:0] cur;
    cur = {bus.chipselect_out, bus.address_out, bus.read_n_out,
           bus.write_n_out, bus.writedata_out};
    if (reset_in) begin
      bus.waitrequest_in = 1'b0;
      stall_cnt = 0;
      prev_done = 0;
    end else begin
      if (bus.busy_out && bus.memory_address_out == '0) saw_zero = 1;
      if (bus.chipselect_out) begin
        cs_cycles++;
        if (prev_done) gap_viol++;
        if (stall_cnt > 0 && cur !== snap) unstable++;
        if (stall_cnt == 0) snap = cur;
        if (stall_cnt < stall_cfg) begin
          bus.waitrequest_in = 1'b1;
          stall_cnt++;
          prev_done = 0;
        end else begin
          bus.waitrequest_in = 1'b0;
          stall_cnt = 0;
          prev_done = 1;
          if (!bus.read_n_out && bus.write_n_out && bus.address_out) begin
            if (slave_ws.size() > 0) ws = 16'(slave_ws.pop_front());
            else                     ws = 16'(def_ws);
            r = $urandom;
            bus.readdata_in = {ws, r[15:0]};
            log_q.push_back(-1);
          end else if (bus.read_n_out && !bus.write_n_out && !bus.address_out)
            log_q.push_back(int'(bus.writedata_out));
          else
            log_q.push_back(-2);
        end
      end else begin
        bus.waitrequest_in = 1'b0;
        stall_cnt = 0;
        prev_done = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Reference: every byte (low first) needs a nonzero WSPACE poll before it,
  // unless cached credit from an earlier poll covers it.
  task automatic build_expect(input int addr, input int cnt);
    int          q[$];
    int          credit;
    int          ws;
    logic [15:0] w;
    logic [7:0]  b;
    q = slave_ws;
    exp_q.delete();
    credit = 0;
    for (int i = 0; i < cnt; i++) begin
      w = mem[(addr + i) % 2048];
      for (int k = 0; k < 2; k++) begin
        b = (k == 0) ? w[7:0] : w[15:8];
        if (!cache || credit == 0) begin
          do begin
            if (q.size() > 0) ws = q.pop_front();
            else              ws = def_ws;
            exp_q.push_back(-1);
          end while (ws == 0);
          credit = ws;
        end
        exp_q.push_back(int'(b));
        credit--;
      end
    end
  endtask

  task automatic run_xfer(input string tag, input int addr, input int cnt, input bit midstart);
    int cyc;
    int obs;
    build_expect(addr, cnt);
    log_q.delete();
    @(negedge clock_in);
    bus.start_in         = 1'b1;
    bus.start_address_in = addr[AW-1:0];
    bus.word_count_in    = cnt[AW-1:0];
    @(negedge clock_in);
    bus.start_in = 1'b0;
    cyc = 0;
    while (bus.done_out !== 1'b1 && cyc < 5000) begin
      if (midstart && cyc == 3) begin
        bus.start_in         = 1'b1;
        bus.start_address_in = ~addr[AW-1:0];
        bus.word_count_in    = 11'd7;
      end else
        bus.start_in = 1'b0;
      @(negedge clock_in);
      cyc++;
    end
    chk({tag, "_done"}, bus.done_out, 1);
    chk({tag, "_busy_at_done"}, bus.busy_out, 0);
    chk({tag, "_txn_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < log_q.size()) ? log_q[i] : -3;
      chk($sformatf("%s_txn%0d", tag, i), obs, exp_q[i]);
    end
    @(negedge clock_in);
    chk({tag, "_done_pulse"}, bus.done_out, 0);
  endtask

  initial begin
    int fw;
    int nrd;
    int cyc;
    int n;
`ifdef UART_TX_WSPACE_CACHE_EN
    cache = 1;
`endif
    reset_in             = 1'b1;
    bus.start_in         = 1'b0;
    bus.start_address_in = '0;
    bus.word_count_in    = '0;
    def_ws    = 1;
    stall_cfg = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);

    // reset behaviour
    repeat (3) @(negedge clock_in);
    chk("rst_strobes", {bus.chipselect_out, bus.address_out, bus.read_n_out, bus.write_n_out}, 4'b0011);
    chk("rst_wdata", bus.writedata_out, 0);
    chk("rst_maddr", bus.memory_address_out, 0);
    chk("rst_busy_done", {bus.busy_out, bus.done_out}, 2'b00);
    reset_in = 1'b0;
    @(negedge clock_in);
    chk("post_rst_strobes", {bus.chipselect_out, bus.read_n_out, bus.write_n_out}, 3'b011);
    chk("post_rst_busy", bus.busy_out, 0);

    // single word, one stall cycle per transaction
    mem[16'h010] = 16'hE1AD;
    slave_ws.delete();
    def_ws    = 16'h0040;
    stall_cfg = 1;
    run_xfer("single", 16'h010, 1, 0);

    // backpressure: three empty polls before space
    slave_ws  = '{0, 0, 0, 1};
    def_ws    = 1;
    stall_cfg = $urandom_range(0, 2);
    run_xfer("bp", $urandom_range(0, 2047), 1, 0);
    fw = -1;
    for (int i = 0; i < log_q.size(); i++) if (fw < 0 && log_q[i] >= 0) fw = i;
    chk("bp_reads_before_write", fw, 4);

    // pointer wrap
    mem[2047] = 16'h0B0A;
    mem[0]    = 16'h0D0C;
    saw_zero  = 0;
    def_ws    = 3;
    run_xfer("wrap", 2047, 2, 0);
    chk("wrap_addr_zero", saw_zero, 1);

    // zero count
    cs_cycles = 0;
    @(negedge clock_in);
    bus.start_in      = 1'b1;
    bus.word_count_in = '0;
    @(negedge clock_in);
    bus.start_in = 1'b0;
    chk("zero_cyc1_done_busy", {bus.done_out, bus.busy_out}, 2'b01);
    @(negedge clock_in);
    chk("zero_cyc2_done_busy", {bus.done_out, bus.busy_out}, 2'b10);
    @(negedge clock_in);
    chk("zero_done_pulse", bus.done_out, 0);
    chk("zero_no_cs", cs_cycles, 0);

    // start while busy is ignored
    slave_ws  = '{0, 2};
    def_ws    = 1;
    stall_cfg = $urandom_range(0, 2);
    run_xfer("midstart", $urandom_range(0, 2047), 3, 1);

    // reset during a data write
    @(negedge clock_in);
    bus.start_in         = 1'b1;
    bus.start_address_in = 11'h123;
    bus.word_count_in    = 11'd2;
    stall_cfg = 2;
    cyc = 0;
    @(negedge clock_in);
    bus.start_in = 1'b0;
    while (bus.write_n_out !== 1'b0 && cyc < 200) begin
      @(negedge clock_in);
      cyc++;
    end
    chk("rstw_reached_write", bus.write_n_out, 0);
    reset_in = 1'b1;
    #1;
    chk("rstw_write_n", bus.write_n_out, 1);
    chk("rstw_cs", bus.chipselect_out, 0);
    chk("rstw_wdata", bus.writedata_out, 0);
    chk("rstw_busy_maddr", {bus.busy_out, 21'(bus.memory_address_out)}, 0);
    repeat (2) @(negedge clock_in);
    reset_in = 1'b0;

    // randomized transfers
    for (int t = 0; t < 6; t++) begin
      slave_ws.delete();
      n = $urandom_range(0, 5);
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 3))
          0:       slave_ws.push_back(0);
          1:       slave_ws.push_back(1);
          2:       slave_ws.push_back(2);
          default: slave_ws.push_back(int'(16'($urandom)));
        endcase
      end
      def_ws    = $urandom_range(1, 3);
      stall_cfg = $urandom_range(0, 2);
      run_xfer($sformatf("rnd%0d", t), $urandom_range(0, 2047), $urandom_range(1, 4), 0);
    end

    // credit caching
    slave_ws.delete();
    def_ws    = 4;
    stall_cfg = 1;
    run_xfer("credit", $urandom_range(0, 2047), 2, 0);
    nrd = 0;
    foreach (log_q[i]) if (log_q[i] == -1) nrd++;
    chk("credit_reads", nrd, cache ? 1 : 4);

    chk("bus_gap_violations", gap_viol, 0);
    chk("bus_unstable_during_stall", unstable, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
